// File: rtl/axis_rx_fifo.sv
// AXI-Stream receive FIFO (first-word-fall-through) with packet counter and packet-state FSM.
// Define AXIS_RX_FIFO_ID_CHECK_EN to compile in the sticky intra-packet ID mismatch check.
`timescale 1ns/1ps

`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif

module axis_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [`AXI_DATA_W-1:0]     axis_data,
  input  logic [`AXI_ID_W-1:0]       axis_id,
  input  logic                       axis_valid,
  output logic                       axis_ready,
  input  logic                       axis_last,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [`AXI_DATA_W-1:0]     rd_data,
  output logic [`AXI_ID_W-1:0]       rd_id,
  output logic                       rd_last,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           pkt_cnt,
  output logic                       id_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic {IDLE, IN_PKT} state_t;

  logic [`AXI_DATA_W-1:0] r_mem_data [DEPTH];
  logic [`AXI_ID_W-1:0]   r_mem_id   [DEPTH];
  logic                   r_mem_last [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [CNT_W-1:0] r_pkt_cnt;
  state_t           r_state, w_state_nxt;

  logic w_push, w_pop;

  // Ready is gated by rst_n so nothing is accepted while reset is held.
  assign axis_ready = rst_n && (r_level < FULL_LVL);
  assign w_push     = axis_valid && axis_ready;
  assign w_pop      = rd_en && (r_level != '0);

  assign rd_valid = (r_level != '0);
  assign rd_data  = r_mem_data[r_rd_ptr];
  assign rd_id    = r_mem_id[r_rd_ptr];
  assign rd_last  = r_mem_last[r_rd_ptr];
  assign level    = r_level;
  assign pkt_cnt  = r_pkt_cnt;

  // Storage has no reset; stale contents are hidden behind rd_valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= axis_data;
      r_mem_id[r_wr_ptr]   <= axis_id;
      r_mem_last[r_wr_ptr] <= axis_last;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_pkt_cnt <= '0;
    else if (w_push && axis_last && (r_pkt_cnt != '1))
      r_pkt_cnt <= r_pkt_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_push && !axis_last) w_state_nxt = IN_PKT;
      IN_PKT:  if (w_push &&  axis_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef AXIS_RX_FIFO_ID_CHECK_EN
  logic [`AXI_ID_W-1:0] r_cap_id;
  logic                 r_id_err;

  // The first beat of a multi-beat packet sets the reference ID for the rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_id <= '0;
      r_id_err <= 1'b0;
    end else begin
      if (r_state == IDLE && w_push && !axis_last)
        r_cap_id <= axis_id;
      if (r_state == IN_PKT && w_push && (axis_id != r_cap_id))
        r_id_err <= 1'b1;
    end
  end

  assign id_err = r_id_err;
`else
  assign id_err = 1'b0;
`endif

endmodule

// File: tb/tb_axis_rx_fifo.sv
// Directed bench for axis_rx_fifo: reset, FWFT packet, full/backpressure, streaming wrap, ID check, mid-packet reset, counter saturation.
`timescale 1ns/1ps

`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif

module tb_axis_rx_fifo;
  localparam int DW = `AXI_DATA_W;
  localparam int IW = `AXI_ID_W;

  logic          clk, rst_n;
  logic [DW-1:0] axis_data;
  logic [IW-1:0] axis_id;
  logic          axis_valid, axis_ready, axis_last, rd_en;
  logic          rd_valid, rd_last, id_err;
  logic [DW-1:0] rd_data;
  logic [IW-1:0] rd_id;
  logic [3:0]    level;
  logic [15:0]   pkt_cnt;

  logic [DW-1:0] s_data;
  logic [IW-1:0] s_id;
  logic          s_valid, s_ready, s_last, s_rd_en;
  logic          s_rd_valid, s_rd_last, s_id_err;
  logic [DW-1:0] s_rd_data;
  logic [IW-1:0] s_rd_id;
  logic [3:0]    s_level;
  logic [1:0]    s_pkt_cnt;

  int total = 0;
  int bad   = 0;
  logic exp_err;

  axis_rx_fifo #(.DEPTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .axis_data(axis_data), .axis_id(axis_id),
    .axis_valid(axis_valid), .axis_ready(axis_ready), .axis_last(axis_last),
    .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data), .rd_id(rd_id),
    .rd_last(rd_last), .level(level), .pkt_cnt(pkt_cnt), .id_err(id_err));

  axis_rx_fifo #(.DEPTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .axis_data(s_data), .axis_id(s_id),
    .axis_valid(s_valid), .axis_ready(s_ready), .axis_last(s_last),
    .rd_en(s_rd_en), .rd_valid(s_rd_valid), .rd_data(s_rd_data), .rd_id(s_rd_id),
    .rd_last(s_rd_last), .level(s_level), .pkt_cnt(s_pkt_cnt), .id_err(s_id_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [IW-1:0] id, input logic last);
    int n = 0;
    axis_valid = 1'b1; axis_data = d; axis_id = id; axis_last = last;
    while (!axis_ready && n < 50) begin tick(); n++; end
    if (!axis_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: axis_ready=%0b required=1", axis_ready);
    end
    tick();
    axis_valid = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1; tick(); rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; #2;
    total += 5;
    if (level !== 4'd0)      begin bad++; $display("FAIL rst_level: got %0d want 0", level); end
    if (rd_valid !== 1'b0)   begin bad++; $display("FAIL rst_rd_valid: got %0b want 0", rd_valid); end
    if (axis_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %0b want 0", axis_ready); end
    if (pkt_cnt !== 16'd0)   begin bad++; $display("FAIL rst_pkt_cnt: got %0d want 0", pkt_cnt); end
    if (id_err !== 1'b0)     begin bad++; $display("FAIL rst_id_err: got %0b want 0", id_err); end
    tick(); tick();
    @(negedge clk); rst_n = 1'b1;
    tick();
    total++;
    if (axis_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %0b want 1", axis_ready); end
  endtask

  task automatic test_packet();
    // Beat offered into an empty FIFO must not show up before the edge.
    axis_valid = 1'b1; axis_data = 32'hA1; axis_id = 4'd2; axis_last = 1'b0;
    #1;
    total++;
    if (rd_valid !== 1'b0) begin bad++; $display("FAIL latency_pre_edge: rd_valid=%0b want 0", rd_valid); end
    tick();
    total++;
    if (rd_valid !== 1'b1) begin bad++; $display("FAIL latency_post_edge: rd_valid=%0b want 1", rd_valid); end
    send(32'hA2, 4'd2, 1'b0);
    send(32'hA3, 4'd2, 1'b1);
    total += 5;
    if (level !== 4'd3)      begin bad++; $display("FAIL pkt_level: got %0d want 3", level); end
    if (pkt_cnt !== 16'd1)   begin bad++; $display("FAIL pkt_cnt: got %0d want 1", pkt_cnt); end
    if (rd_data !== 32'hA1)  begin bad++; $display("FAIL pkt_head_data: got %h want a1", rd_data); end
    if (rd_last !== 1'b0)    begin bad++; $display("FAIL pkt_head_last: got %0b want 0", rd_last); end
    if (rd_id !== 4'd2)      begin bad++; $display("FAIL pkt_head_id: got %0d want 2", rd_id); end
    pop(); pop();
    total += 2;
    if (rd_data !== 32'hA3) begin bad++; $display("FAIL pkt_tail_data: got %h want a3", rd_data); end
    if (rd_last !== 1'b1)   begin bad++; $display("FAIL pkt_tail_last: got %0b want 1", rd_last); end
    pop();
  endtask

  task automatic test_full();
    axis_valid = 1'b1; axis_id = 4'd1; axis_last = 1'b1;
    for (int i = 0; i < 8; i++) begin
      axis_data = 32'h10 + i;
      total++;
      if (axis_ready !== 1'b1) begin bad++; $display("FAIL full_ready_%0d: got %0b want 1", i, axis_ready); end
      tick();
    end
    total += 2;
    if (level !== 4'd8)      begin bad++; $display("FAIL full_level: got %0d want 8", level); end
    if (axis_ready !== 1'b0) begin bad++; $display("FAIL full_ready_low: got %0b want 0", axis_ready); end
    axis_data = 32'h18;
    tick();
    total += 2;
    if (level !== 4'd8)      begin bad++; $display("FAIL full_hold_level: got %0d want 8", level); end
    if (axis_ready !== 1'b0) begin bad++; $display("FAIL full_hold_ready: got %0b want 0", axis_ready); end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    total += 2;
    if (level !== 4'd7)      begin bad++; $display("FAIL full_pop_level: got %0d want 7", level); end
    if (axis_ready !== 1'b1) begin bad++; $display("FAIL full_pop_ready: got %0b want 1", axis_ready); end
    tick();
    axis_valid = 1'b0;
    total++;
    if (level !== 4'd8) begin bad++; $display("FAIL full_ninth_level: got %0d want 8", level); end
    for (int j = 0; j < 8; j++) begin
      total++;
      if (rd_data !== 32'h11 + j) begin bad++; $display("FAIL full_drain_%0d: got %h want %h", j, rd_data, 32'h11 + j); end
      pop();
    end
    pop();
    total += 3;
    if (level !== 4'd0)     begin bad++; $display("FAIL empty_pop_level: got %0d want 0", level); end
    if (rd_valid !== 1'b0)  begin bad++; $display("FAIL empty_rd_valid: got %0b want 0", rd_valid); end
    if (pkt_cnt !== 16'd10) begin bad++; $display("FAIL full_pkt_cnt: got %0d want 10", pkt_cnt); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) send(32'h30 + i, 4'd4, 1'b1);
    axis_id = 4'd4; axis_last = 1'b1;
    for (int i = 0; i < 20; i++) begin
      axis_valid = 1'b1; rd_en = 1'b1; axis_data = 32'h34 + i;
      total += 2;
      if (rd_data !== 32'h30 + i) begin bad++; $display("FAIL b2b_data_%0d: got %h want %h", i, rd_data, 32'h30 + i); end
      if (level !== 4'd4)         begin bad++; $display("FAIL b2b_level_%0d: got %0d want 4", i, level); end
      tick();
    end
    axis_valid = 1'b0; rd_en = 1'b0;
    total++;
    if (level !== 4'd4) begin bad++; $display("FAIL b2b_final_level: got %0d want 4", level); end
    for (int j = 0; j < 4; j++) begin
      total++;
      if (rd_data !== 32'h44 + j) begin bad++; $display("FAIL b2b_drain_%0d: got %h want %h", j, rd_data, 32'h44 + j); end
      pop();
    end
    total++;
    if (pkt_cnt !== 16'd34) begin bad++; $display("FAIL b2b_pkt_cnt: got %0d want 34", pkt_cnt); end
  endtask

  task automatic test_id_check();
`ifdef AXIS_RX_FIFO_ID_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    send(32'h50, 4'd5, 1'b0);
    send(32'h51, 4'd5, 1'b0);
    total++;
    if (id_err !== 1'b0) begin bad++; $display("FAIL id_err_early: got %0b want 0", id_err); end
    send(32'h52, 4'd6, 1'b1);
    total += 2;
    if (id_err !== exp_err) begin bad++; $display("FAIL id_err_set: got %0b want %0b", id_err, exp_err); end
    if (level !== 4'd3)     begin bad++; $display("FAIL id_beats_stored: got %0d want 3", level); end
    send(32'h53, 4'd1, 1'b1);
    tick();
    total++;
    if (id_err !== exp_err) begin bad++; $display("FAIL id_err_sticky: got %0b want %0b", id_err, exp_err); end
    for (int j = 0; j < 4; j++) pop();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) send(32'h60 + i, 4'd3, 1'b0);
    total++;
    if (level !== 4'd5) begin bad++; $display("FAIL mid_level_pre: got %0d want 5", level); end
    rst_n = 1'b0; #2;
    total += 4;
    if (level !== 4'd0)    begin bad++; $display("FAIL mid_rst_level: got %0d want 0", level); end
    if (rd_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_rd_valid: got %0b want 0", rd_valid); end
    if (pkt_cnt !== 16'd0) begin bad++; $display("FAIL mid_rst_pkt_cnt: got %0d want 0", pkt_cnt); end
    if (id_err !== 1'b0)   begin bad++; $display("FAIL mid_rst_id_err: got %0b want 0", id_err); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    send(32'h70, 4'd7, 1'b0);
    send(32'h71, 4'd7, 1'b1);
    total += 4;
    if (pkt_cnt !== 16'd1)  begin bad++; $display("FAIL mid_next_pkt_cnt: got %0d want 1", pkt_cnt); end
    if (level !== 4'd2)     begin bad++; $display("FAIL mid_next_level: got %0d want 2", level); end
    if (rd_data !== 32'h70) begin bad++; $display("FAIL mid_next_head: got %h want 70", rd_data); end
    if (id_err !== 1'b0)    begin bad++; $display("FAIL mid_next_id_err: got %0b want 0", id_err); end
    pop(); pop();
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    s_rd_en = 1'b1; s_last = 1'b1; s_id = 4'd0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 32'h80 + i;
      tick();
      s_valid = 1'b0;
      total++;
      if (s_pkt_cnt !== exp_cnt[i]) begin bad++; $display("FAIL sat_cnt_%0d: got %0d want %0d", i, s_pkt_cnt, exp_cnt[i]); end
    end
  endtask

  initial begin
    rst_n = 1'b0; axis_valid = 1'b0; axis_data = '0; axis_id = '0; axis_last = 1'b0; rd_en = 1'b0;
    s_valid = 1'b0; s_data = '0; s_id = '0; s_last = 1'b0; s_rd_en = 1'b0;
    test_reset();
    test_packet();
    test_full();
    test_back_to_back();
    test_id_check();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axis_rx_fifo.md
AXIS_RX_FIFO -- requirements
Module: axis_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entry count; power of two, 2..64.
REQ-002 SHALL have parameter CNT_W, default 16, width of pkt_cnt.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port axis_data  input  `AXI_DATA_W  stream beat data.
REQ-006 SHALL have port axis_id  input  `AXI_ID_W  stream ID.
REQ-007 SHALL have port axis_valid  input  1  upstream beat valid.
REQ-008 SHALL have port axis_ready  output  1  slave ready.
REQ-009 SHALL have port axis_last  input  1  final beat of packet.
REQ-010 SHALL have port rd_en  input  1  pop request.
REQ-011 SHALL have port rd_valid  output  1  FIFO non-empty.
REQ-012 SHALL have port rd_data  output  `AXI_DATA_W  head-entry data.
REQ-013 SHALL have port rd_id  output  `AXI_ID_W  head-entry ID.
REQ-014 SHALL have port rd_last  output  1  head-entry last flag.
REQ-015 SHALL have port level  output  $clog2(DEPTH)+1  entries held.
REQ-016 SHALL have port pkt_cnt  output  CNT_W  packets accepted since reset.
REQ-017 SHALL have port id_err  output  1  sticky intra-packet ID mismatch flag.

Function
REQ-018 SHALL assert axis_ready combinationally when level < DEPTH and rst_n is high.
REQ-019 SHALL push {data,id,last} on a rising edge where axis_valid and axis_ready are both 1.
REQ-020 SHALL present the head entry on rd_data/rd_id/rd_last first-word-fall-through; rd_valid = (level != 0).
REQ-021 SHALL pop on a rising edge where rd_en and rd_valid are both 1; rd_en while empty is ignored.
REQ-022 SHALL add 1-cycle push-to-rd_valid latency; no combinational path from axis_valid to rd_valid.
REQ-023 SHALL on simultaneous push and pop keep level unchanged and write/read pointers both advance.
REQ-024 SHALL keep axis_ready low while full; a pop at full raises axis_ready the following cycle.
REQ-025 SHALL wrap read and write pointers modulo DEPTH.
REQ-026 SHALL increment pkt_cnt on each accepted beat with axis_last=1, saturating at 2^CNT_W-1.
REQ-027 SHALL track packet state with FSM IDLE/IN_PKT: IDLE->IN_PKT on accepted beat with last=0 (capture axis_id); IN_PKT->IDLE on accepted beat with last=1; otherwise hold.
REQ-028 SHALL treat an accepted last=1 beat in IDLE as a single-beat packet (stay IDLE).
REQ-029 SHALL never drop or reorder accepted beats.

Reset
REQ-030 SHALL on rst_n low immediately clear pointers, level=0, rd_valid=0, axis_ready=0, pkt_cnt=0, id_err=0, FSM=IDLE.
REQ-031 SHALL discard FIFO contents on reset mid-packet; rd_data/rd_id/rd_last are don't-care while rd_valid=0.
REQ-032 SHALL assert axis_ready from the first rising edge after rst_n deasserts.

Configuration
REQ-033 SHALL use macro AXIS_RX_FIFO_ID_CHECK_EN to compile the ID check in or out.
REQ-034 SHALL with the macro defined set id_err on an accepted beat in IN_PKT whose axis_id differs from the captured ID; id_err stays 1 until reset; beat is still stored.
REQ-035 SHALL without the macro tie id_err to 0 and keep the port present; FIFO, FSM and pkt_cnt unchanged.

Verification
REQ-036 SHALL cover: 3-beat packet id=2 data 0xA1,0xA2,0xA3, rd_en=0 -> level=3, pkt_cnt=1, rd_data=0xA1, rd_last=0.
REQ-037 SHALL cover: DEPTH=8, 9 beats offered back-to-back, no pops -> axis_ready=0 after 8th accept, 9th held; one pop -> 9th accepted next cycle.
REQ-038 SHALL cover: push and pop every cycle for 20 cycles at level=4 -> level stays 4, output order equals input order across pointer wrap.
REQ-039 SHALL cover: macro defined, packet ids 5,5,6 (last on third) -> id_err=1 after third beat and stays 1; macro undefined -> id_err=0.
REQ-040 SHALL cover: rst_n low mid-packet with level=5 -> level=0, rd_valid=0, pkt_cnt=0 without clock edge; next packet counted as pkt_cnt=1.
REQ-041 SHALL cover: CNT_W=2, 5 single-beat packets -> pkt_cnt saturates at 3.
